card_payment_terminal: RTL
==========================

Name: card_payment_terminal

Overview:
- Payment-side counterpart of the vending controller; acts as the card reader/authorizer at the other end of the CARD_IN / COST / VALID_TRAN handshake.
- Accepts a card swipe carrying a balance and presents CARD_IN to the vending controller.
- Authorizes the price code the controller drives on COST, answers with VALID_TRAN or a decline, and debits the balance once VEND confirms delivery.
- Sits between the card-reader front end and the vending controller's transaction inputs.

Parameters:
AUTH_LATENCY, 3, cycles from COST capture to the decision; legal range 1..4, kept below the controller's 5-cycle payment timeout.
BAL_W, 8, width in bits of the card balance.

Ports:
CLK  input  1  system clock; all state changes on its rising edge.
RESET  input  1  asynchronous, active-high reset.
CARD_SWIPE  input  1  one-cycle pulse: card read, CARD_BALANCE valid.
CARD_BALANCE  input  BAL_W  card balance, sampled on CARD_SWIPE.
CARD_REMOVE  input  1  user pulled the card; aborts any open transaction.
COST  input  3  price code from the vending controller; non-zero means a payment request.
VEND  input  1  vending controller is dispensing; commits the debit.
FAILED_TRAN  input  1  controller timed out on payment.
INVALID_SEL  input  1  controller rejected the selection.
CARD_IN  output  1  card present, held level toward the controller.
VALID_TRAN  output  1  payment approved, held level.
DECLINED  output  1  one-cycle pulse: insufficient balance.
BALANCE  output  BAL_W  current card balance.
BUSY  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: all outputs 0; FSM returns to IDLE. RESET applies at any time, including mid-transaction, with no debit performed.
- IDLE
  - CARD_IN=0.
  - On CARD_SWIPE: BALANCE<=CARD_BALANCE; go to PRESENT.
  - CARD_SWIPE is ignored in every other state.
- PRESENT
  - CARD_IN=1.
  - COST!=0: latch COST into a cost register, load the latency counter with AUTH_LATENCY, go to AUTH.
  - INVALID_SEL or CARD_REMOVE: go to EJECT.
- AUTH
  - CARD_IN=1. Counter decrements each cycle. COST changes are ignored.
  - When the counter reaches 0:
    - If BALANCE >= latched cost (cost zero-extended to BAL_W): go to APPROVED.
    - Otherwise: pulse DECLINED for 1 cycle and go to DECL.
  - CARD_REMOVE or FAILED_TRAN: go to EJECT; no decision is issued.
  - Latency: VALID_TRAN rises AUTH_LATENCY+1 cycles after the COST sample edge.
- APPROVED
  - VALID_TRAN=1, CARD_IN=1.
  - VEND: BALANCE<=BALANCE-cost, go to EJECT. Cannot underflow, since the balance was checked.
  - VEND and FAILED_TRAN in the same cycle: VEND wins.
  - FAILED_TRAN alone or CARD_REMOVE: go to EJECT, no debit.
- DECL
  - VALID_TRAN=0, CARD_IN=1.
  - Waits for FAILED_TRAN or CARD_REMOVE, then goes to EJECT.
- EJECT
  - CARD_IN=0, VALID_TRAN=0 for exactly 1 cycle, then IDLE.
  - This guarantees the controller's idle state sees CARD_IN low before any new card.
- BALANCE holds its value in IDLE until the next swipe.

Optional Feature:
TXN_LOG_EN
- Defined: adds outputs APPROVED_CNT[7:0] and DECLINED_CNT[7:0].
  - APPROVED_CNT increments on each VEND commit.
  - DECLINED_CNT increments on each DECLINED pulse.
  - Both saturate at 255 and clear only on RESET.
- Undefined: both ports are present but tied to 0; no counter logic is built.

Test Plan:
1. Reset mid-APPROVED → next cycle all outputs 0, FSM in IDLE, BALANCE 0.
2. Swipe with CARD_BALANCE=10, COST=3 for one cycle, VEND 2 cycles after VALID_TRAN → VALID_TRAN high 4 cycles after the COST edge, BALANCE=7, CARD_IN low 1 cycle, then IDLE.
3. Swipe with CARD_BALANCE=2, COST=5 → DECLINED pulses once, VALID_TRAN stays 0; FAILED_TRAN → EJECT → IDLE, BALANCE=2. With TXN_LOG_EN, DECLINED_CNT=1.
4. Approved, then VEND and FAILED_TRAN asserted in the same cycle → debit applied, BALANCE=balance-cost.
5. CARD_REMOVE during AUTH with 1 cycle left → no VALID_TRAN, no DECLINED, BALANCE unchanged, EJECT → IDLE.
6. CARD_SWIPE while in APPROVED → ignored, BALANCE unchanged; COST changed during AUTH → decision uses the originally latched cost.

Source files
------------

// File: rtl/card_payment_terminal.sv
// Card reader/authorizer facing a vending controller: presents the card, authorizes COST, debits on VEND.
// Optional macro TXN_LOG_EN builds saturating approved/declined transaction counters.
module card_payment_terminal #(
  parameter int AUTH_LATENCY = 3,
  parameter int BAL_W        = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             card_swipe_i,
  input  logic [BAL_W-1:0] card_balance_i,
  input  logic             card_remove_i,
  input  logic [2:0]       cost_i,
  input  logic             vend_i,
  input  logic             failed_tran_i,
  input  logic             invalid_sel_i,
  output logic             card_in_o,
  output logic             valid_tran_o,
  output logic             declined_o,
  output logic [BAL_W-1:0] balance_o,
  output logic             busy_o,
  output logic [7:0]       approved_cnt_o,
  output logic [7:0]       declined_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRESENT, S_AUTH, S_APPROVED, S_DECL, S_EJECT
  } state_e;

  localparam logic [2:0] LAT = 3'(AUTH_LATENCY);

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [2:0]       cost_q, cost_d;
  logic [BAL_W-1:0] balance_q, balance_d;
  logic             declined_q, declined_d;
  logic             commit;
  logic [BAL_W-1:0] cost_ext;

  assign cost_ext = BAL_W'(cost_q);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cost_d       = cost_q;
    balance_d    = balance_q;
    declined_d   = 1'b0;
    commit       = 1'b0;
    card_in_o    = 1'b0;
    valid_tran_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (card_swipe_i) begin
          balance_d = card_balance_i;
          state_d   = S_PRESENT;
        end
      end
      S_PRESENT: begin
        card_in_o = 1'b1;
        if (invalid_sel_i || card_remove_i) begin
          state_d = S_EJECT;
        end else if (cost_i != 3'd0) begin
          cost_d  = cost_i;
          cnt_d   = LAT;
          state_d = S_AUTH;
        end
      end
      S_AUTH: begin
        card_in_o = 1'b1;
        // An abort always beats the decision, even on the last counted cycle.
        if (card_remove_i || failed_tran_i) begin
          state_d = S_EJECT;
        end else if (cnt_q == 3'd0) begin
          if (balance_q >= cost_ext) begin
            state_d = S_APPROVED;
          end else begin
            declined_d = 1'b1;
            state_d    = S_DECL;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_APPROVED: begin
        card_in_o    = 1'b1;
        valid_tran_o = 1'b1;
        if (vend_i) begin
          balance_d = balance_q - cost_ext;
          commit    = 1'b1;
          state_d   = S_EJECT;
        end else if (failed_tran_i || card_remove_i) begin
          state_d = S_EJECT;
        end
      end
      S_DECL: begin
        card_in_o = 1'b1;
        if (failed_tran_i || card_remove_i) state_d = S_EJECT;
      end
      S_EJECT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cost_q     <= '0;
      balance_q  <= '0;
      declined_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cost_q     <= cost_d;
      balance_q  <= balance_d;
      declined_q <= declined_d;
    end
  end

  assign declined_o = declined_q;
  assign balance_o  = balance_q;
  assign busy_o     = (state_q != S_IDLE);

`ifdef TXN_LOG_EN
  logic [7:0] appr_cnt_q, decl_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      appr_cnt_q <= '0;
      decl_cnt_q <= '0;
    end else begin
      if (commit && appr_cnt_q != 8'hFF)     appr_cnt_q <= appr_cnt_q + 8'd1;
      if (declined_d && decl_cnt_q != 8'hFF) decl_cnt_q <= decl_cnt_q + 8'd1;
    end
  end

  assign approved_cnt_o = appr_cnt_q;
  assign declined_cnt_o = decl_cnt_q;
`else
  logic unused_commit;
  assign unused_commit  = commit;
  assign approved_cnt_o = '0;
  assign declined_cnt_o = '0;
`endif

endmodule
